// File: rtl/sigma_bus_arbiter.sv
// ----------------------------------------------------------------------------
// sigma_bus_arbiter
//
// Two-master to one-slave bus arbiter with in-order read response routing.
// The grant is combinational from the current requests. The grant policy is
// either fixed priority for master 0 or round-robin between the two masters.
// Each accepted read pushes the granted master ID into a small ID FIFO. Each
// slave read response pops the head ID and routes the data to that master.
// A response that arrives while no read is outstanding raises a sticky error.
//
// Parameters
//   RESP_DEPTH   maximum outstanding reads (power of two, 2..16)
//   M0_PRIORITY  1: master 0 has fixed priority, 0: round-robin
//
// Ports
//   clk_i, arst_n_i              clock, asynchronous active-low reset
//   mX_req_i/we_i/addr_bi/be_bi/wdata_bi   master X request channel
//   mX_ack_o                     master X request accepted this cycle
//   mX_resp_o, mX_rdata_bo       master X read data valid / read data
//   s_req_o/we_o/addr_bo/be_bo/wdata_bo    request to the shared slave
//   s_ack_i                      slave accepted the request
//   s_resp_i, s_rdata_bi         slave read response / read data
//   err_o                        sticky: response arrived with nothing pending
// ----------------------------------------------------------------------------
module sigma_bus_arbiter #(
    parameter int unsigned RESP_DEPTH  = 4,
    parameter bit          M0_PRIORITY = 1'b0
) (
    input  logic        clk_i,
    input  logic        arst_n_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_bi,
    input  logic [3:0]  m0_be_bi,
    input  logic [31:0] m0_wdata_bi,
    output logic        m0_ack_o,
    output logic        m0_resp_o,
    output logic [31:0] m0_rdata_bo,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_bi,
    input  logic [3:0]  m1_be_bi,
    input  logic [31:0] m1_wdata_bi,
    output logic        m1_ack_o,
    output logic        m1_resp_o,
    output logic [31:0] m1_rdata_bo,

    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_bo,
    output logic [3:0]  s_be_bo,
    output logic [31:0] s_wdata_bo,
    input  logic        s_ack_i,
    input  logic        s_resp_i,
    input  logic [31:0] s_rdata_bi,

    output logic        err_o
);

    localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        MST_0 = 1'b0,
        MST_1 = 1'b1
    } master_e;

    // Round-robin state: the master that wins the next tie.
    master_e              rr_pref_q, rr_pref_d;

    // Outstanding-read ID FIFO.
    logic [RESP_DEPTH-1:0] id_mem_q;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;

    logic                  err_q, err_d;

    logic    fifo_full;
    logic    fifo_empty;
    logic    m0_elig;
    logic    m1_elig;
    logic    gnt_valid;
    master_e gnt_id;
    master_e head_id;
    logic    accept;
    logic    push;
    logic    pop;

    // Full is judged on occupancy before any same-cycle pop, so a read is
    // held off for one extra cycle when a response frees the last slot.
    assign fifo_full  = (count_q == CNT_W'(RESP_DEPTH));
    assign fifo_empty = (count_q == '0);

    // Reads need a free FIFO slot; writes never produce a response. The grant
    // is masked during reset so the bus stays quiet while arst_n_i is low.
    assign m0_elig = arst_n_i & m0_req_i & (m0_we_i | ~fifo_full);
    assign m1_elig = arst_n_i & m1_req_i & (m1_we_i | ~fifo_full);

    // ------------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------------
    always_comb begin
        gnt_valid = m0_elig | m1_elig;
        gnt_id    = MST_0;
        if (M0_PRIORITY) begin
            gnt_id = m0_elig ? MST_0 : MST_1;
        end else if (m0_elig && m1_elig) begin
            gnt_id = rr_pref_q;
        end else begin
            gnt_id = m0_elig ? MST_0 : MST_1;
        end
    end

    // ------------------------------------------------------------------------
    // Slave request mux and master acknowledges
    // ------------------------------------------------------------------------
    always_comb begin
        s_req_o    = 1'b0;
        s_we_o     = 1'b0;
        s_addr_bo  = '0;
        s_be_bo    = '0;
        s_wdata_bo = '0;
        if (gnt_valid) begin
            s_req_o = 1'b1;
            if (gnt_id == MST_0) begin
                s_we_o     = m0_we_i;
                s_addr_bo  = m0_addr_bi;
                s_be_bo    = m0_be_bi;
                s_wdata_bo = m0_wdata_bi;
            end else begin
                s_we_o     = m1_we_i;
                s_addr_bo  = m1_addr_bi;
                s_be_bo    = m1_be_bi;
                s_wdata_bo = m1_wdata_bi;
            end
        end
    end

    assign accept   = s_req_o & s_ack_i;
    assign push     = accept & ~s_we_o;
    assign m0_ack_o = accept & (gnt_id == MST_0);
    assign m1_ack_o = accept & (gnt_id == MST_1);

    // ------------------------------------------------------------------------
    // Response routing: strictly in order, steered by the FIFO head ID
    // ------------------------------------------------------------------------
    assign head_id = master_e'(id_mem_q[rd_ptr_q]);
    assign pop     = s_resp_i & ~fifo_empty;

    always_comb begin
        m0_resp_o   = 1'b0;
        m1_resp_o   = 1'b0;
        m0_rdata_bo = '0;
        m1_rdata_bo = '0;
        if (pop) begin
            if (head_id == MST_0) begin
                m0_resp_o   = 1'b1;
                m0_rdata_bo = s_rdata_bi;
            end else begin
                m1_resp_o   = 1'b1;
                m1_rdata_bo = s_rdata_bi;
            end
        end
    end

    assign err_o = err_q;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        rr_pref_d = rr_pref_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_d     = err_q;

        // Only an accepted transfer moves the round-robin preference.
        if (accept) begin
            rr_pref_d = (gnt_id == MST_0) ? MST_1 : MST_0;
        end

        // Pointers wrap naturally since RESP_DEPTH is a power of two.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (s_resp_i && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rr_pref_q <= MST_0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            id_mem_q  <= '0;
        end else begin
            rr_pref_q <= rr_pref_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
            if (push) begin
                id_mem_q[wr_ptr_q] <= gnt_id;
            end
        end
    end

endmodule
